// File: rtl/string_uart_tx_if.sv
// Host-side string transmitter bus: start/string request plus the serial line and status.
interface string_uart_tx_if #(
   parameter int NCHARS    = 11,
   parameter int CHAR_BITS = 7
);
   logic                          start;
   logic [0:NCHARS*CHAR_BITS-1]   String;
   logic                          txd;
   logic                          busy;
   logic                          done;
   logic [3:0]                    char_idx;

   modport master (output start, String, input txd, busy, done, char_idx);
   modport slave  (input start, String, output txd, busy, done, char_idx);
endinterface

// File: rtl/string_uart_tx.sv
// Sends a latched NCHARS x CHAR_BITS string as back-to-back UART frames (8N1).
// Define STRING_UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module string_uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int NCHARS    = 11,
   parameter int CHAR_BITS = 7
) (
   input  logic              clk,
   input  logic              reset,
   string_uart_tx_if.slave   bus
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

`ifdef STRING_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                      state, state_n;
   logic [CW-1:0]               baud_cnt;
   logic [2:0]                  bit_cnt;
   logic [3:0]                  char_idx;
   logic                        done_q, done_n;
   logic [0:NCHARS*CHAR_BITS-1] shadow;
   logic [CHAR_BITS-1:0]        cur_char;
   logic [7:0]                  cur_byte;
   logic                        tick, last, txd_c;

   assign tick = (baud_cnt == CW'(CPB - 1));
   assign last = (char_idx == 4'(NCHARS - 1));

   // Lowest string index lands in the MSB of the character; upper byte bits stay zero.
   always_comb begin
      cur_char = shadow[int'(char_idx)*CHAR_BITS +: CHAR_BITS];
      cur_byte = 8'(cur_char);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         char_idx <= '0;
         done_q   <= 1'b0;
         shadow   <= '0;
      end else begin
         state  <= state_n;
         done_q <= done_n;
         if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (bus.start) begin
               shadow   <= bus.String;
               char_idx <= '0;
            end
         end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (tick && state == DATA) bit_cnt <= bit_cnt + 3'd1;
            if (tick && state == STOP) char_idx <= last ? 4'd0 : char_idx + 4'd1;
         end
      end
   end

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      case (state)
         IDLE:   if (bus.start) state_n = START;
         START:  if (tick) state_n = DATA;
         DATA:
            if (tick && bit_cnt == 3'd7) begin
`ifdef STRING_UART_TX_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            end
`ifdef STRING_UART_TX_PARITY_EN
         PARITY: if (tick) state_n = STOP;
`endif
         STOP:
            if (tick) begin
               // Next frame starts immediately; only the last one returns to idle.
               if (last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = START;
               end
            end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      txd_c = 1'b1;
      case (state)
         START:  txd_c = 1'b0;
         DATA:   txd_c = cur_byte[bit_cnt];
`ifdef STRING_UART_TX_PARITY_EN
         PARITY: txd_c = ^cur_byte;
`endif
         default: txd_c = 1'b1;
      endcase
   end

   assign bus.txd      = txd_c;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.char_idx = char_idx;
endmodule

// File: tb/tb_string_uart_tx.sv
// Directed bench: single-char frames on a 1-char instance, "HELLO WORLD" on an 11-char instance.
module tb_string_uart_tx;
   localparam int CPB = 16;
`ifdef STRING_UART_TX_PARITY_EN
   localparam int FB = 11;
   localparam logic [10:0] FRAME_A = 11'b10010000010;
   localparam logic [10:0] FRAME_C = 11'b11010000110;
`else
   localparam int FB = 10;
   localparam logic [10:0] FRAME_A = 11'b01010000010;
   localparam logic [10:0] FRAME_C = 11'b01010000110;
`endif

   logic clk = 1'b0;
   logic reset;
   int   ncmp = 0, nerr = 0;
   int   cyc = 0, ndone = 0, cyc_done = 0;
   logic [7:0] exp11 [11] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20,
                              8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
   logic [0:76] hello;

   always #5 clk = ~clk;

   string_uart_tx_if #(.NCHARS(1),  .CHAR_BITS(7)) b1 ();
   string_uart_tx_if #(.NCHARS(11), .CHAR_BITS(7)) b11 ();

   string_uart_tx #(.CLK_FREQ(16), .BAUD(1), .NCHARS(1),  .CHAR_BITS(7))
      u1  (.clk(clk), .reset(reset), .bus(b1));
   string_uart_tx #(.CLK_FREQ(16), .BAUD(1), .NCHARS(11), .CHAR_BITS(7))
      u11 (.clk(clk), .reset(reset), .bus(b11));

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (b11.done === 1'b1) begin
         ndone    <= ndone + 1;
         cyc_done <= cyc;
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full frame on u1 from the start pulse to the done pulse.
   task automatic send1(input string tag, input logic [6:0] ch, input logic [10:0] frame);
      int bad;
      b1.String = ch;
      b1.start  = 1'b1;
      tick();
      b1.start  = 1'b0;
      chk({tag, "_lat_txd"},  b1.txd, 0);
      chk({tag, "_lat_busy"}, b1.busy, 1);
      bad = 0;
      for (int b = 0; b < FB; b++)
         for (int c = 0; c < CPB; c++) begin
            if (b1.txd !== frame[b] || b1.busy !== 1'b1 || b1.done !== 1'b0) bad++;
            tick();
         end
      chk({tag, "_bits"}, bad, 0);
      chk({tag, "_done"}, b1.done, 1);
      chk({tag, "_busy_end"}, b1.busy, 0);
      tick();
      chk({tag, "_done_1cyc"}, b1.done, 0);
   endtask

   // Mid-bit sampling UART receiver on u11, then compare against the expected byte.
   task automatic rx_check(input int k);
      logic [7:0] d;
      logic       par;
      int         n;
      bit         to;
      d = '0; par = 1'b0; n = 0; to = 0;
      while (b11.txd !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      if (b11.txd !== 1'b0) to = 1;
      chk($sformatf("rx_timeout_%0d", k), 32'(to), 0);
      if (to) return;
      repeat (7) tick();
      chk($sformatf("rx_start_%0d", k), b11.txd, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) tick();
         d[i] = b11.txd;
      end
`ifdef STRING_UART_TX_PARITY_EN
      repeat (CPB) tick();
      par = b11.txd;
      chk($sformatf("rx_par_%0d", k), par, ^exp11[k]);
`endif
      repeat (CPB) tick();
      chk($sformatf("rx_stop_%0d", k), b11.txd, 1);
      chk($sformatf("rx_byte_%0d", k), d, exp11[k]);
   endtask

   task automatic wait_done(input int nd0);
      int n;
      n = 0;
      while (ndone == nd0 && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      string      hw;
      logic [7:0] c;
      int         bad, nd0, c0;
      hw = "HELLO WORLD";
      for (int k = 0; k < 11; k++) begin
         c = hw[k];
         hello[k*7 +: 7] = c[6:0];
      end

      reset = 1'b1;
      b1.start = 1'b0;  b1.String = '0;
      b11.start = 1'b0; b11.String = '0;
      repeat (3) tick();
      chk("rst_txd",  b1.txd, 1);
      chk("rst_busy", b1.busy, 0);
      chk("rst_done", b1.done, 0);
      chk("rst_idx",  b11.char_idx, 0);
      reset = 1'b0;

      bad = 0;
      repeat (100) begin
         tick();
         if (b1.txd !== 1'b1 || b1.busy !== 1'b0 || b1.done !== 1'b0) bad++;
      end
      chk("idle100", bad, 0);

      send1("A", 7'h41, FRAME_A);
      send1("C", 7'h43, FRAME_C);

      // start held high: re-accepted on the done cycle, one idle-high cycle between transfers
      b1.String = 7'h41;
      b1.start  = 1'b1;
      tick();
      repeat (FB*CPB) tick();
      chk("hold_done", b1.done, 1);
      chk("hold_gap",  b1.txd, 1);
      tick();
      chk("hold_restart_busy", b1.busy, 1);
      chk("hold_restart_txd",  b1.txd, 0);
      b1.start = 1'b0;
      repeat (FB*CPB) tick();
      chk("hold_second_done", b1.done, 1);

      // clean HELLO WORLD transfer
      nd0 = ndone;
      b11.String = hello;
      b11.start = 1'b1;
      tick();
      b11.start = 1'b0;
      c0 = cyc;
      chk("hw_busy", b11.busy, 1);
      chk("hw_idx0", b11.char_idx, 0);
      for (int k = 0; k < 11; k++) rx_check(k);
      wait_done(nd0);
      chk("hw_done_cnt", ndone - nd0, 1);
      chk("hw_len", cyc_done - c0, 11*FB*CPB);
      tick();
      chk("hw_idle_idx", b11.char_idx, 0);

      // start re-pulsed and String scrambled while busy: latched copy still sent, nothing queued
      nd0 = ndone;
      b11.start = 1'b1;
      tick();
      b11.start = 1'b0;
      for (int k = 0; k < 11; k++) begin
         rx_check(k);
         if (k == 2) begin
            b11.String = '1;
            b11.start  = 1'b1;
            tick();
            b11.start  = 1'b0;
         end
      end
      wait_done(nd0);
      repeat (40) tick();
      chk("busy_ign_done_cnt", ndone - nd0, 1);
      chk("busy_ign_busy", b11.busy, 0);
      chk("busy_ign_txd", b11.txd, 1);

      // reset during DATA of char 3
      b11.String = hello;
      nd0 = ndone;
      b11.start = 1'b1;
      tick();
      b11.start = 1'b0;
      for (int k = 0; k < 3; k++) rx_check(k);
      repeat (9 + CPB + 24) tick();
      chk("mid_idx3", b11.char_idx, 3);
      chk("mid_busy", b11.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_txd",  b11.txd, 1);
      chk("abort_busy", b11.busy, 0);
      chk("abort_idx",  b11.char_idx, 0);
      repeat (30) tick();
      chk("abort_no_done", ndone - nd0, 0);

      // fresh transfer after the abort starts from char 0
      nd0 = ndone;
      b11.start = 1'b1;
      tick();
      b11.start = 1'b0;
      for (int k = 0; k < 11; k++) rx_check(k);
      wait_done(nd0);
      chk("fresh_done_cnt", ndone - nd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/string_uart_tx.md
Name: string_uart_tx

Overview:
- Serial transmitter for the POV display link: the other end of the receiver that assembles the 77-bit LED string.
- Latches an NCHARS x CHAR_BITS string on a start pulse and sends it character by character as UART frames on txd.
- Frame format: 8N1, optional parity.
- Used by the host-side/test board to drive the mobile display board, and as a loopback source for the receiver.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- NCHARS, 11, number of characters per string.
- CHAR_BITS, 7, bits per character; must be <= 8.
- CLKS_PER_BIT (local), CLK_FREQ/BAUD (integer division, 5208 at defaults), cycles per serial bit.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to send String; sampled only in IDLE.
- String  in  [0:NCHARS*CHAR_BITS-1]  character k = String[k*CHAR_BITS +: CHAR_BITS] in ascending index order; lowest index of each character is its MSB.
- txd  out  1  serial line, idle high.
- busy  out  1  high from the cycle after an accepted start until the end of the last stop bit.
- done  out  1  one-cycle pulse after the final stop bit of the last character.
- char_idx  out  4  index of the character currently being sent; 0 when idle.

Behaviour:
- Reset values: txd=1, busy=0, done=0, char_idx=0, state=IDLE, baud counter=0, bit counter=0.
- Reset asserted mid-frame aborts the transfer on the next clock edge: txd=1 and busy=0 on that same edge; no done pulse.
- FSM states: IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
  - IDLE: when start=1, latch String into shadow register, char_idx=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits sent LSB first. Data byte = zero-extended character ({(8-CHAR_BITS) zeros, char}); bits above CHAR_BITS are sent as 0. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to PARITY if enabled, else STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
    - If char_idx < NCHARS-1: char_idx++, go to START; no idle gap between frames.
    - Otherwise: go to IDLE and pulse done on that edge; busy drops on the same edge.
- Latency: txd falls (start bit) on the clock edge immediately after the cycle in which start=1 was sampled in IDLE. busy rises on that same edge.
- Full transfer: NCHARS*10*CLKS_PER_BIT cycles (11 bits per frame with parity).
- Bit timing: baud counter counts 0..CLKS_PER_BIT-1, and a bit boundary occurs on wrap. txd changes only at bit boundaries.
- start while busy: ignored; no queuing.
- String changes while busy: no effect; the shadow copy is sent.
- start held high continuously: a new transfer begins on the edge after the done edge, giving a 1-cycle idle-high gap minimum.
- done and start in the same cycle: start is accepted; done still pulses.

Optional Feature:
- Macro: STRING_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit. Frame = 11 bits.
- Undefined: no PARITY state; 10-bit frames, 8N1.

Test Plan:
- Reset then idle (CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16) -> txd=1, busy=0, done=0 for 100 cycles; start held 0.
- Single string, NCHARS=1, CHAR_BITS=7, String=7'b1000001 ('A'=0x41), one-cycle start -> txd pattern per 16-cycle bit: 0, 1,0,0,0,0,0,1,0, 1. done pulses at cycle 160 after start, busy high for cycles 1-160.
- Default NCHARS=11, String = "HELLO WORLD" as 7-bit ASCII -> bench UART decoder receives bytes 0x48,0x45,0x4C,0x4C,0x4F,0x20,0x57,0x4F,0x52,0x4C,0x44 in order, back-to-back; exactly one done pulse.
- Start re-pulsed mid-transfer and String changed while busy -> output byte stream identical to the original latched string; no second transfer starts.
- reset asserted during the DATA state of char 3 -> next edge: txd=1, busy=0, char_idx=0, no done pulse. A fresh start afterwards sends from char 0 correctly.
- With STRING_UART_TX_PARITY_EN, String=0x41 -> parity bit 0 (two ones), 11-bit frame. With 0x43 -> parity bit 1.
